frame_collect_n_m: RTL and testbench
====================================

Name: frame_collect_n_m

Overview:
- Upstream stage of the m-word summing pipeline.
- Gathers a serial stream of n-bit words into an m-word frame with a valid/ready handshake, then presents the frame as an unpacked array to the downstream adder.
- Holds the frame until the consumer accepts it.
- Supports a flush that emits a partial, zero-padded frame.

Parameters:
- n, 32, word width in bits
- m, 4, words per frame (m >= 2)

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  reset; asynchronous, active-high
- in_data_i  input  n  incoming word
- in_valid_i  input  1  in_data_i is valid this cycle
- in_ready_o  output  1  block can accept a word this cycle
- flush_i  input  1  close the current partial frame
- frame_o  output  n x m, unpacked [0:m-1]  frame words; index 0 is the first word received
- frame_valid_o  output  1  frame_o holds a complete or flushed frame
- frame_ready_i  input  1  consumer takes the frame this cycle
- frame_cnt_o  output  $clog2(m+1)  number of real words in the presented frame (1..m)
- busy_o  output  1  fill index nonzero or a frame is held

Behaviour:
- Reset (asynchronous, on rst_i high):
  - state = FILL, fill index = 0, all frame words = 0
  - frame_valid_o = 0, frame_cnt_o = 0, busy_o = 0, in_ready_o = 1 (in FILL after reset)
- Word accept: in_valid_i && in_ready_o. The word is written to frame[idx] and idx increments.
- State FILL:
  - in_ready_o = 1, frame_valid_o = 0.
  - If a word is accepted at idx = m-1: go to FULL, frame_cnt_o = m, idx = 0.
  - Latency: last word accepted in cycle k gives frame_valid_o = 1 in cycle k+1.
- State FULL:
  - in_ready_o = 0, frame_valid_o = 1.
  - frame_o and frame_cnt_o are stable until the handshake.
  - On frame_valid_o && frame_ready_i: go to FILL and clear all frame words to 0 in the same edge.
  - in_ready_o is 1 in the following cycle.
- Flush:
  - flush_i in FILL with idx > 0: go to FULL, frame_cnt_o = idx, unwritten words remain 0.
  - If flush_i coincides with an accepted word, the word is stored first; frame_cnt_o = idx+1.
  - If that word also completes the frame, it is a normal full frame with frame_cnt_o = m.
  - flush_i with idx = 0 is ignored. flush_i in FULL is ignored.
- Backpressure: frame_ready_i held low keeps FULL indefinitely. No word is ever dropped or overwritten.
- frame_ready_i while frame_valid_o = 0 has no effect.
- in_valid_i while in_ready_o = 0 has no effect, and the word is not captured.
- Reset mid-frame discards the partial frame and any held frame. There is no output pulse.
- Index counter wraps only via the FULL transition. It never exceeds m-1.

Optional Feature:
- Macro: FRAME_COLLECT_DOUBLE_BUF_EN.
- Defined:
  - Two banks (A, B) in ping-pong.
  - While one bank is presented (FULL), the other fills.
  - in_ready_o = 0 only when both banks are full.
  - The oldest full bank is presented first.
  - If the presented bank is accepted in the same cycle the other bank completes, the other bank is presented in the next cycle, so frame_valid_o stays 1 without a gap.
  - Flush applies to the filling bank only.
- Undefined: single bank, exact behaviour above.

Decomposition:
- Package frame_collect_pkg:
  - state enum {FILL, FULL}
  - function for index width, $clog2(m)
  - localparam for the count width, $clog2(m+1)
- Sub-module frame_bank:
  - one m-word register bank
  - inputs: write enable, write index, data, synchronous clear
  - outputs: the array
  - instantiated once, or twice under FRAME_COLLECT_DOUBLE_BUF_EN

Test Plan (n=32, m=4):
- Full frame: reset, then send 0x11, 0x22, 0x33, 0x44 on consecutive cycles with frame_ready_i = 0 → frame_valid_o = 1 the cycle after 0x44. frame_o = {0x11, 0x22, 0x33, 0x44}. frame_cnt_o = 4. in_ready_o = 0.
- Backpressure: hold frame_ready_i = 0 for 10 cycles while driving in_valid_i with 0x55 → frame_o unchanged and 0x55 not captured. Raise frame_ready_i → next cycle frame_valid_o = 0, in_ready_o = 1, frame words = 0.
- Flush: send 0xA, 0xB, then assert flush_i alone → frame_o = {0xA, 0xB, 0, 0}, frame_cnt_o = 2. Flush coincident with a third word 0xC → frame_cnt_o = 3.
- Idle flush and reset: flush_i with idx = 0 → no frame_valid_o. Reset asserted after 2 words → all outputs return to reset values. Next frame starts at index 0.
- Back-to-back with frame_ready_i tied 1: 8 words streamed → two frames, each presented for exactly 1 cycle. Single-buffer build: 1-cycle in_ready_o gap per frame.
- Double buffer (FRAME_COLLECT_DOUBLE_BUF_EN): frame_ready_i = 0, 8 words → in_ready_o drops only after word 8. Release frame_ready_i for 2 cycles → frames {1..4} then {5..8} presented in order, with no gap.

Source files
------------

// File: rtl/frame_collect_n_m_pkg.sv
// Shared types and sizing helpers for the frame collector.
//   state_e  : FILL / FULL state encoding
//   idx_w()  : width of the fill index for an m-word frame
//   cnt_w()  : width of the word-count output for an m-word frame
package frame_collect_pkg;

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_e;

  function automatic int idx_w(input int m);
    return $clog2(m);
  endfunction

  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction

  // Count width for the default 4-word frame.
  localparam int M_DEF     = 4;
  localparam int CNT_W_DEF = $clog2(M_DEF + 1);

endpackage

// File: rtl/frame_collect_n_m_if.sv
// Word-in / frame-out handshake bundle of the frame collector.
//   in_data_i/in_valid_i/in_ready_o       : serial word stream
//   flush_i                               : close a partial frame
//   frame_o/frame_valid_o/frame_ready_i   : frame presented downstream
//   frame_cnt_o                           : real words in the frame
//   busy_o                                : partial or held frame present
// slave modport is the collector, master modport is the driver/consumer side.
interface frame_collect_n_m_if
  import frame_collect_pkg::*;
#(
  parameter int n = 32,
  parameter int m = 4
);
  logic [n-1:0]          in_data_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic                  flush_i;
  logic [n-1:0]          frame_o [0:m-1];
  logic                  frame_valid_o;
  logic                  frame_ready_i;
  logic [cnt_w(m)-1:0]   frame_cnt_o;
  logic                  busy_o;

  modport slave (
    input  in_data_i, in_valid_i, flush_i, frame_ready_i,
    output in_ready_o, frame_o, frame_valid_o, frame_cnt_o, busy_o
  );

  modport master (
    output in_data_i, in_valid_i, flush_i, frame_ready_i,
    input  in_ready_o, frame_o, frame_valid_o, frame_cnt_o, busy_o
  );
endinterface

// File: rtl/frame_collect_n_m_bank.sv
// One m-word register bank.
//   we_i/widx_i/wdata_i : write one word at widx_i
//   clr_i               : synchronous clear of every word
//   words_o             : the stored array, index 0 first
// A write in the same cycle as a clear wins for its own word.
module frame_bank
  import frame_collect_pkg::*;
#(
  parameter int n = 32,
  parameter int m = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [idx_w(m)-1:0]   widx_i,
  input  logic [n-1:0]          wdata_i,
  input  logic                  clr_i,
  output logic [n-1:0]          words_o [0:m-1]
);
  localparam int IW = idx_w(m);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < m; i++) words_o[i] <= '0;
    end else begin
      for (int i = 0; i < m; i++) begin
        if (clr_i) words_o[i] <= '0;
        if (we_i && widx_i == IW'(i)) words_o[i] <= wdata_i;
      end
    end
  end
endmodule

// File: rtl/frame_collect_n_m.sv
// Frame collector: packs a serial stream of n-bit words into m-word frames
// and holds each frame until the downstream adder takes it. A flush closes
// a partial frame; unwritten words stay zero.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : slave side of frame_collect_n_m_if
// Build option FRAME_COLLECT_DOUBLE_BUF_EN: two ping-pong banks so one can
// fill while the other is presented; otherwise a single bank.
module frame_collect_n_m
  import frame_collect_pkg::*;
#(
  parameter int n = 32,
  parameter int m = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  frame_collect_n_m_if.slave   bus
);
  localparam int IW = idx_w(m);
  localparam int CW = cnt_w(m);

  logic [IW-1:0] idx;
  logic          accept;
  logic          last;

  assign accept = bus.in_valid_i && bus.in_ready_o;
  assign last   = (idx == IW'(m - 1));

`ifdef FRAME_COLLECT_DOUBLE_BUF_EN
  // wb: bank being filled, rb: bank being presented. Both advance strictly
  // alternately, so rb always points at the oldest full bank.
  logic [1:0]    full;
  logic          wb, rb;
  logic [CW-1:0] cnt [2];
  logic          pop;
  logic [n-1:0]  words [2][0:m-1];

  assign pop = full[rb] && bus.frame_ready_i;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank #(.n(n), .m(m)) u_bank (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (accept && (wb == 1'(b))),
      .widx_i  (idx),
      .wdata_i (bus.in_data_i),
      .clr_i   (pop && (rb == 1'(b))),
      .words_o (words[b])
    );
  end

  assign bus.in_ready_o    = !full[wb];
  assign bus.frame_valid_o = full[rb];
  assign bus.frame_cnt_o   = cnt[rb];
  assign bus.busy_o        = (idx != '0) || (full != 2'b00);

  always_comb begin
    for (int i = 0; i < m; i++) bus.frame_o[i] = words[rb][i];
  end

  // pop touches bank rb (full), completion touches bank wb (not full):
  // never the same bank in one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full   <= 2'b00;
      wb     <= 1'b0;
      rb     <= 1'b0;
      idx    <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      if (pop) begin
        full[rb] <= 1'b0;
        cnt[rb]  <= '0;
        rb       <= ~rb;
      end
      if (accept) begin
        if (last || bus.flush_i) begin
          full[wb] <= 1'b1;
          cnt[wb]  <= last ? CW'(m) : CW'(idx) + CW'(1);
          wb       <= ~wb;
          idx      <= '0;
        end else begin
          idx <= idx + IW'(1);
        end
      end else if (bus.flush_i && idx != '0 && !full[wb]) begin
        full[wb] <= 1'b1;
        cnt[wb]  <= CW'(idx);
        wb       <= ~wb;
        idx      <= '0;
      end
    end
  end
`else
  localparam logic [0:0] S_FILL = 1'(FILL);
  localparam logic [0:0] S_FULL = 1'(FULL);

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          clr;

  // Handshake on the held frame clears the bank in the same edge.
  assign clr = (state == S_FULL) && bus.frame_ready_i;

  frame_bank #(.n(n), .m(m)) u_bank (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (accept),
    .widx_i  (idx),
    .wdata_i (bus.in_data_i),
    .clr_i   (clr),
    .words_o (bus.frame_o)
  );

  assign bus.in_ready_o    = (state == S_FILL);
  assign bus.frame_valid_o = (state == S_FULL);
  assign bus.frame_cnt_o   = cnt;
  assign bus.busy_o        = (idx != '0) || (state == S_FULL);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_FILL;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (accept) begin
            // A word arriving with flush is stored first; completing the
            // frame takes precedence and gives a full count.
            if (last || bus.flush_i) begin
              state <= S_FULL;
              cnt   <= last ? CW'(m) : CW'(idx) + CW'(1);
              idx   <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end else if (bus.flush_i && idx != '0) begin
            state <= S_FULL;
            cnt   <= CW'(idx);
            idx   <= '0;
          end
        end
        default: begin
          if (bus.frame_ready_i) begin
            state <= S_FILL;
            cnt   <= '0;
          end
        end
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_frame_collect_n_m.sv
module tb_frame_collect_n_m;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  frame_collect_n_m_if #(.n(32), .m(4)) bus ();

  frame_collect_n_m #(.n(32), .m(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [31:0] w0, w1, w2, w3);
    chk({tag, "[0]"}, bus.frame_o[0], w0);
    chk({tag, "[1]"}, bus.frame_o[1], w1);
    chk({tag, "[2]"}, bus.frame_o[2], w2);
    chk({tag, "[3]"}, bus.frame_o[3], w3);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = d;
    tick();
    bus.in_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sent, frames, gaps, run, maxrun;
    logic acc;
    bus.in_data_i     = '0;
    bus.in_valid_i    = 1'b0;
    bus.flush_i       = 1'b0;
    bus.frame_ready_i = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.frame_valid_o, 0);
    chk("rst_cnt", bus.frame_cnt_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_ready", bus.in_ready_o, 1);
    chk_frame("rst_frame", 0, 0, 0, 0);
    rst = 1'b0;
    tick();

    // full frame
    send(32'h11); send(32'h22); send(32'h33);
    chk("ff_valid_early", bus.frame_valid_o, 0);
    chk("ff_busy_partial", bus.busy_o, 1);
    send(32'h44);
    chk("ff_valid", bus.frame_valid_o, 1);
    chk_frame("ff_frame", 32'h11, 32'h22, 32'h33, 32'h44);
    chk("ff_cnt", bus.frame_cnt_o, 4);
`ifdef FRAME_COLLECT_DOUBLE_BUF_EN
    chk("ff_in_ready", bus.in_ready_o, 1);
`else
    chk("ff_in_ready", bus.in_ready_o, 0);
`endif

    // backpressure
`ifndef FRAME_COLLECT_DOUBLE_BUF_EN
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 32'h55;
`endif
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_valid", bus.frame_valid_o, 1);
      chk("bp_w3", bus.frame_o[3], 32'h44);
    end
    chk_frame("bp_frame", 32'h11, 32'h22, 32'h33, 32'h44);
    bus.in_valid_i    = 1'b0;
    bus.frame_ready_i = 1'b1;
    tick();
    bus.frame_ready_i = 1'b0;
    chk("bp_rel_valid", bus.frame_valid_o, 0);
    chk("bp_rel_ready", bus.in_ready_o, 1);
    chk("bp_rel_cnt", bus.frame_cnt_o, 0);
    chk("bp_rel_busy", bus.busy_o, 0);
    chk_frame("bp_rel_frame", 0, 0, 0, 0);

    // flush alone after two words
    send(32'hA); send(32'hB);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("fl_valid", bus.frame_valid_o, 1);
    chk("fl_cnt", bus.frame_cnt_o, 2);
    chk_frame("fl_frame", 32'hA, 32'hB, 0, 0);
    bus.frame_ready_i = 1'b1;
    tick();
    bus.frame_ready_i = 1'b0;
    chk("fl_rel_valid", bus.frame_valid_o, 0);

    // flush coincident with third word
    send(32'hA); send(32'hB);
    bus.flush_i = 1'b1;
    send(32'hC);
    bus.flush_i = 1'b0;
    chk("flc_valid", bus.frame_valid_o, 1);
    chk("flc_cnt", bus.frame_cnt_o, 3);
    chk_frame("flc_frame", 32'hA, 32'hB, 32'hC, 0);
    bus.frame_ready_i = 1'b1;
    tick();
    bus.frame_ready_i = 1'b0;

    // idle flush ignored
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("if_valid", bus.frame_valid_o, 0);
    chk("if_busy", bus.busy_o, 0);

    // reset mid-frame (asynchronous)
    send(32'h1); send(32'h2);
    chk("mr_busy_before", bus.busy_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_valid", bus.frame_valid_o, 0);
    chk("mr_busy", bus.busy_o, 0);
    chk("mr_cnt", bus.frame_cnt_o, 0);
    chk("mr_ready", bus.in_ready_o, 1);
    chk_frame("mr_frame", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    send(32'h1); send(32'h2); send(32'h3); send(32'h4);
    chk("mr_next_valid", bus.frame_valid_o, 1);
    chk_frame("mr_next_frame", 1, 2, 3, 4);
    bus.frame_ready_i = 1'b1;
    tick();

    // back-to-back with frame_ready_i held high
    sent = 0; frames = 0; gaps = 0; run = 0; maxrun = 0;
    for (int c = 0; c < 16; c++) begin
      acc            = bus.in_ready_o && (sent < 8);
      bus.in_valid_i = acc;
      bus.in_data_i  = 32'(sent + 1);
      tick();
      if (acc) sent++;
      if (!bus.in_ready_o) gaps++;
      if (bus.frame_valid_o) begin
        frames++;
        run++;
        if (run > maxrun) maxrun = run;
        chk("b2b_w0", bus.frame_o[0], 32'(4 * (frames - 1) + 1));
        chk("b2b_w3", bus.frame_o[3], 32'(4 * frames));
      end else begin
        run = 0;
      end
    end
    bus.in_valid_i    = 1'b0;
    bus.frame_ready_i = 1'b0;
    chk("b2b_sent", sent, 8);
    chk("b2b_frames", frames, 2);
    chk("b2b_maxrun", maxrun, 1);
`ifdef FRAME_COLLECT_DOUBLE_BUF_EN
    chk("b2b_gaps", gaps, 0);
`else
    chk("b2b_gaps", gaps, 2);
`endif

`ifdef FRAME_COLLECT_DOUBLE_BUF_EN
    // ping-pong: both banks fill before in_ready_o drops
    for (int w = 1; w <= 8; w++) begin
      chk("db_ready", bus.in_ready_o, 1);
      send(32'(w));
    end
    chk("db_ready_full", bus.in_ready_o, 0);
    chk("db_valid", bus.frame_valid_o, 1);
    chk_frame("db_first", 1, 2, 3, 4);
    bus.frame_ready_i = 1'b1;
    tick();
    chk("db_valid2", bus.frame_valid_o, 1);
    chk("db_cnt2", bus.frame_cnt_o, 4);
    chk_frame("db_second", 5, 6, 7, 8);
    tick();
    bus.frame_ready_i = 1'b0;
    chk("db_done_valid", bus.frame_valid_o, 0);
    chk("db_done_ready", bus.in_ready_o, 1);
    chk("db_done_busy", bus.busy_o, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
